ysyx_22050612_data_mem_responder: RTL and testbench
===================================================

// Module: ysyx_22050612_data_mem_responder
// PURPOSE
//   Memory-side responder for the execute unit's load/store port. It replaces the
//   zero-latency DPI pmem_read/pmem_write path with a clocked slave.
//   Accepts one 64-bit word request (read, or byte-masked write) over a valid/ready
//   channel, models a programmable access latency, and returns data/ack on a
//   valid/ready response channel. Backed by an internal word array.
//   Lane extraction and sign extension stay in the requester.
// PARAMETERS
//   ADDR_W   10             word-index width; array holds 2**ADDR_W 64-bit words
//   BASE     64'h8000_0000  byte address mapped to word 0
//   LATENCY  2              cycles from request acceptance to rsp_valid; legal 1..15
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active-high
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_wen    in   1   1 = write, 0 = read
//   req_addr   in   64  byte address; bits [2:0] ignored (word access)
//   req_wdata  in   64  write data, lane-aligned like the requester's wdata
//   req_wmask  in   8   byte-enable; bit i writes byte i of the word
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester accepts response
//   rsp_rdata  out  64  full aligned word for reads; 0 for writes and errors
//   rsp_err    out  1   address outside [BASE, BASE + 8*2**ADDR_W)
// BEHAVIOUR
//   - FSM states:
//     IDLE -(req_valid & req_ready)-> WAIT -(cnt==0)-> RESP -(rsp_ready)-> IDLE.
//   - req_ready = (state==IDLE). rsp_valid = (state==RESP). One transaction
//     outstanding at a time; no new request is accepted in WAIT or RESP.
//   - On acceptance: latch wen, addr, wdata, wmask. Load the latency counter with
//     LATENCY-1.
//   - WAIT: the counter decrements once per cycle. On the edge where cnt==0, the
//     access commits:
//     - write: only bytes with wmask=1 are updated; the rest of the word is
//       untouched.
//     - read: the word is captured into rsp_rdata.
//     - The FSM enters RESP on that same edge.
//   - Latency: acceptance at edge N gives rsp_valid high after edge N+LATENCY.
//     For LATENCY=1 the FSM passes through WAIT for exactly one cycle.
//   - Index = (addr - BASE) >> 3. It is valid only if addr >= BASE and
//     index < 2**ADDR_W.
//   - Out-of-range requests: no array write; rsp_rdata=0 and rsp_err=1 in RESP.
//     Latency is the same as an in-range access.
//   - wmask=0 write: no array change; still acked with rsp_err per the range rule.
//   - In RESP with rsp_ready=0: rsp_valid, rsp_rdata and rsp_err hold stable until
//     the handshake.
//   - rsp_ready while rsp_valid=0 is ignored. req_* inputs outside IDLE are ignored.
//   - Read-after-write to the same word returns the merged new contents.
//   - Reset (async, any state):
//     - Control outputs: state=IDLE, req_ready=1 after release, rsp_valid=0,
//       rsp_rdata=0, rsp_err=0, cnt=0.
//     - A write still in WAIT is dropped and never committed.
//     - Array contents are not reset. The bench preloads through a hierarchical
//       task or $readmemh.
//   - Widths: address arithmetic is 64-bit unsigned, so an address below BASE
//     wraps and is rejected by the range check.
// TESTING
//   - Reset, then a write: LATENCY=2; write 0x1122334455667788 with mask 0xFF to
//     0x80000010. Then read 0x80000010 -> rsp_rdata=0x1122334455667788, rsp_err=0.
//     rsp_valid rises exactly 2 cycles after each acceptance.
//   - Masked write: preload word 0x80000010 = 0xFFFFFFFFFFFFFFFF. Write
//     wdata=0x0000AB0000000000, mask 0x20, then read back
//     -> 0xFFFFABFFFFFFFFFF.
//   - Response backpressure: hold rsp_ready=0 for 5 cycles on a read
//     -> rsp_valid and rsp_rdata stay stable, req_ready=0 throughout.
//     Raise rsp_ready -> IDLE next cycle.
//   - Range check: read 0x7FFFFFF8 and 0x80002000 (ADDR_W=10)
//     -> rsp_err=1, rdata=0. A write to 0x80002000 leaves word 0 unchanged.
//   - Reset mid-operation: assert rst during WAIT of a write to 0x80000000
//     -> rsp_valid=0 immediately; a later read of 0x80000000 returns the
//     pre-write value.
//   - Back-to-back traffic: 100 random in-range read/write pairs with LATENCY=1 and
//     random rsp_ready stalls -> all reads match the scoreboard and no request is
//     accepted while rsp_valid=1.

Source files
------------

// File: rtl/ysyx_22050612_data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ysyx_22050612_data_mem_responder
// Description : Clocked single-outstanding memory slave for the load/store
//               port, with a programmable access latency and byte-masked writes.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050612_data_mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned c_DEPTH    = 1 << ADDR_W;
    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_WAIT     = 2'd1;
    localparam logic [1:0]  c_RESP     = 2'd2;
    localparam logic [3:0]  c_CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_wen;
    logic [63:0]       r_addr;
    logic [63:0]       r_wdata;
    logic [7:0]        r_wmask;
    logic [63:0]       r_rdata;
    logic              r_err;
    logic [63:0]       r_mem [c_DEPTH];

    logic [63:0]       w_offset;
    logic [ADDR_W-1:0] w_index;
    logic              w_in_range;
    logic              w_commit;
    logic              w_unused;

    // 64-bit unsigned subtraction: addresses below BASE wrap to huge offsets
    // and fail the upper-bits check as well as the explicit >= test.
    assign w_offset   = r_addr - BASE;
    assign w_index    = w_offset[ADDR_W+2:3];
    assign w_in_range = (r_addr >= BASE) && (w_offset[63:ADDR_W+3] == '0);
    assign w_commit   = (r_state == c_WAIT) && (r_cnt == 4'd0);
    assign w_unused   = ^w_offset[2:0];

    assign req_ready = (r_state == c_IDLE);
    assign rsp_valid = (r_state == c_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_wen   <= 1'b0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_wmask <= 8'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_wen   <= req_wen;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_wmask <= req_wmask;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rdata <= (w_in_range && !r_wen) ? r_mem[w_index] : 64'd0;
                        r_err   <= !w_in_range;
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Array is deliberately not reset; an async reset returns r_state to IDLE,
    // so a write still pending in WAIT never reaches this commit.
    always_ff @(posedge clk) begin
        if (w_commit && r_wen && w_in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (r_wmask[i]) begin
                    r_mem[w_index][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for ysyx_22050612_data_mem_responder: one LATENCY=2 instance for directed
// cases and one LATENCY=1 instance for randomized traffic, both checked every cycle.
module tb_ysyx_22050612_data_mem_responder;

    localparam logic [63:0] c_BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wen   [2];
    logic [63:0] req_addr  [2];
    logic [63:0] req_wdata [2];
    logic [7:0]  req_wmask [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ysyx_22050612_data_mem_responder #(.ADDR_W(10), .BASE(c_BASE), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    ysyx_22050612_data_mem_responder #(.ADDR_W(10), .BASE(c_BASE), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // ---------------- transaction-level reference model ----------------
    bit          m_busy  [2];
    bit          m_resp  [2];
    int          m_left  [2];
    logic        p_wen   [2];
    logic [63:0] p_addr  [2];
    logic [63:0] p_wdata [2];
    logic [7:0]  p_mask  [2];
    logic [63:0] e_rdata [2];
    logic        e_err   [2];
    bit          e_known [2];
    logic [63:0] mm [2][1024];
    bit          mk [2][1024];

    task automatic model_commit(input int u);
        logic [63:0] off;
        logic [9:0]  idx;
        bit          inr;
        off = p_addr[u] - c_BASE;
        inr = (p_addr[u] >= c_BASE) && (off < 64'h2000);
        idx = off[12:3];
        e_err[u]   = !inr;
        e_rdata[u] = 64'd0;
        e_known[u] = 1'b1;
        if (inr && p_wen[u]) begin
            for (int b = 0; b < 8; b++)
                if (p_mask[u][b]) mm[u][idx][8*b +: 8] = p_wdata[u][8*b +: 8];
            if (p_mask[u] == 8'hFF) mk[u][idx] = 1'b1;
        end else if (inr) begin
            e_rdata[u] = mm[u][idx];
            e_known[u] = mk[u][idx];
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_busy[u] = 1'b0;
                m_resp[u] = 1'b0;
            end else if (m_resp[u]) begin
                if (rsp_ready[u]) begin
                    m_resp[u] = 1'b0;
                    m_busy[u] = 1'b0;
                end
            end else if (m_busy[u]) begin
                m_left[u] = m_left[u] - 1;
                if (m_left[u] == 0) begin
                    m_resp[u] = 1'b1;
                    model_commit(u);
                end
            end else if (req_valid[u]) begin
                m_busy[u]  = 1'b1;
                m_left[u]  = (u == 0) ? 2 : 1;
                p_wen[u]   = req_wen[u];
                p_addr[u]  = req_addr[u];
                p_wdata[u] = req_wdata[u];
                p_mask[u]  = req_wmask[u];
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic send(input int u, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] mask);
        bit acc;
        acc = 1'b0;
        req_valid[u] = 1'b1;
        req_wen[u]   = wen;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        req_wmask[u] = mask;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = req_ready[u];
            @(posedge clk); #2;
        end
        if (!acc) timeout("accept");
        // keep valid asserted with garbage payload: it must be ignored while busy
        req_wen[u]   = ~wen;
        req_addr[u]  = ~addr;
        req_wdata[u] = ~wdata;
        req_wmask[u] = ~mask;
    endtask

    task automatic finish_req(input int u, input int stall, output int lat,
                              output logic [63:0] rdata, output logic err);
        lat = 0;
        if (stall > 0) rsp_ready[u] = 1'b0;
        while (!rsp_valid[u] && lat < 40) begin
            @(posedge clk); #2;
            lat++;
        end
        req_valid[u] = 1'b0;
        if (!rsp_valid[u]) timeout("response");
        rdata = rsp_rdata[u];
        err   = rsp_err[u];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #2;
        end
        rsp_ready[u] = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic xfer(input int u, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] mask, input int stall,
                        output int lat, output logic [63:0] rdata, output logic err);
        send(u, wen, addr, wdata, mask);
        finish_req(u, stall, lat, rdata, err);
    endtask

    // ---------------- stimulus and per-cycle comparison ----------------
    initial begin : main
        int          lat;
        logic [63:0] rd;
        logic        er;
        int          w;
        int          r;

        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_wen[u] = 1'b0; req_addr[u] = 64'd0;
            req_wdata[u] = 64'd0; req_wmask[u] = 8'd0; rsp_ready[u] = 1'b1;
        end

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    for (int u = 0; u < 2; u++) begin
                        check($sformatf("cyc_req_ready%0d", u), req_ready[u], !m_busy[u]);
                        check($sformatf("cyc_rsp_valid%0d", u), rsp_valid[u], m_resp[u]);
                        if (m_resp[u]) begin
                            check($sformatf("cyc_rsp_err%0d", u), rsp_err[u], e_err[u]);
                            if (e_known[u])
                                check($sformatf("cyc_rsp_rdata%0d", u), rsp_rdata[u], e_rdata[u]);
                        end
                    end
                end
            end
        join_none

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_rsp_valid", rsp_valid[0], 1'b0);
        check("reset_rsp_rdata", rsp_rdata[0], 64'd0);
        check("reset_rsp_err", rsp_err[0], 1'b0);
        rst = 1'b0;
        @(posedge clk); #2;
        check("reset_req_ready", req_ready[0], 1'b1);

        // full write then read back, latency 2
        xfer(0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, lat, rd, er);
        check("wr_latency", lat, 2);
        check("wr_err", er, 1'b0);
        check("wr_rdata", rd, 64'd0);
        xfer(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, lat, rd, er);
        check("rd_latency", lat, 2);
        check("rd_rdata", rd, 64'h1122_3344_5566_7788);
        check("rd_err", er, 1'b0);

        // single-byte masked merge
        xfer(0, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, lat, rd, er);
        xfer(0, 1'b1, 64'h8000_0010, 64'h0000_AB00_0000_0000, 8'h20, 0, lat, rd, er);
        xfer(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, lat, rd, er);
        check("mask_rdata", rd, 64'hFFFF_ABFF_FFFF_FFFF);

        // zero-mask write leaves the word alone
        xfer(0, 1'b1, 64'h8000_0010, 64'h0, 8'h00, 0, lat, rd, er);
        check("zmask_err", er, 1'b0);
        xfer(0, 1'b0, 64'h8000_0014, 64'd0, 8'h00, 0, lat, rd, er);
        check("zmask_rdata", rd, 64'hFFFF_ABFF_FFFF_FFFF);

        // response backpressure for 5 cycles
        rsp_ready[0] = 1'b0;
        send(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00);
        for (int i = 0; i < 10 && !rsp_valid[0]; i++) begin
            @(posedge clk); #2;
        end
        req_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid[0], 1'b1);
            check("bp_rsp_rdata", rsp_rdata[0], 64'hFFFF_ABFF_FFFF_FFFF);
            check("bp_req_ready", req_ready[0], 1'b0);
            @(posedge clk); #2;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #2;
        check("bp_idle_ready", req_ready[0], 1'b1);
        check("bp_idle_valid", rsp_valid[0], 1'b0);

        // range checks
        xfer(0, 1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, lat, rd, er);
        xfer(0, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0, lat, rd, er);
        check("low_err", er, 1'b1);
        check("low_rdata", rd, 64'd0);
        check("low_latency", lat, 2);
        xfer(0, 1'b0, 64'h8000_2000, 64'd0, 8'h00, 0, lat, rd, er);
        check("high_err", er, 1'b1);
        check("high_rdata", rd, 64'd0);
        xfer(0, 1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, lat, rd, er);
        check("high_wr_err", er, 1'b1);
        xfer(0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, lat, rd, er);
        check("word0_intact", rd, 64'h0123_4567_89AB_CDEF);

        // reset while a write is one edge away from committing
        send(0, 1'b1, 64'h8000_0000, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_rsp_valid", rsp_valid[0], 1'b0);
        check("rst_rsp_err", rsp_err[0], 1'b0);
        req_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        xfer(0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, lat, rd, er);
        check("rst_dropped_write", rd, 64'h0123_4567_89AB_CDEF);

        // randomized traffic on the LATENCY=1 instance
        for (int i = 0; i < 16; i++)
            xfer(1, 1'b1, c_BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 0, lat, rd, er);
        xfer(1, 1'b0, c_BASE, 64'd0, 8'h00, 0, lat, rd, er);
        check("lat1_latency", lat, 1);
        for (int i = 0; i < 100; i++) begin
            w = $urandom_range(0, 15);
            r = $urandom_range(0, 1) ? w : $urandom_range(0, 15);
            xfer(1, 1'b1, c_BASE + 64'(8 * w) + 64'($urandom_range(0, 7)), {$urandom, $urandom},
                 8'($urandom_range(0, 255)), $urandom_range(0, 3), lat, rd, er);
            xfer(1, 1'b0, c_BASE + 64'(8 * r), 64'd0, 8'h00, $urandom_range(0, 3), lat, rd, er);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
